// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared constants for the data-memory arbiter
package dmem_pkg;
    localparam int XLEN      = 64;
    localparam int MEM_WORDS = 256;

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACCESS = 1'b1;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;
endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin pick with its priority pointer
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       update_i,
    input  logic       owner_i,
    output logic       winner_o
);
    import dmem_pkg::*;

    logic rr_ptr_q, rr_ptr_d;

    // After each completed access the other port gets priority.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (update_i) begin
            rr_ptr_d = ~owner_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= PORT0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_comb begin
        winner_o = rr_ptr_q;
        case (req_i)
            2'b01:   winner_o = PORT0;
            2'b10:   winner_o = PORT1;
            default: winner_o = rr_ptr_q;
        endcase
    end
endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port request/grant sequencer for the 64-bit data memory
module dmem_arbiter #(
    parameter int XLEN      = dmem_pkg::XLEN,
    parameter int MEM_WORDS = dmem_pkg::MEM_WORDS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            p0_req,
    input  logic            p0_we,
    input  logic [XLEN-1:0] p0_addr,
    input  logic [XLEN-1:0] p0_wdata,
    output logic            p0_gnt,
    output logic            p0_done,
    output logic            p0_err,
    output logic [XLEN-1:0] p0_rdata,
    input  logic            p1_req,
    input  logic            p1_we,
    input  logic [XLEN-1:0] p1_addr,
    input  logic [XLEN-1:0] p1_wdata,
    output logic            p1_gnt,
    output logic            p1_done,
    output logic            p1_err,
    output logic [XLEN-1:0] p1_rdata,
    output logic            mem_read,
    output logic            mem_write,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata
);
    import dmem_pkg::*;

    localparam logic [XLEN-1:0] ADDR_LIMIT = XLEN'(MEM_WORDS * 8);

    logic [0:0]      state_q, state_d;
    logic [1:0]      gnt_q, gnt_d;
    logic [1:0]      done_q, done_d;
    logic [1:0]      err_q, err_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic            we_q, we_d;
    logic            owner_q, owner_d;
    logic            cmd_err_q, cmd_err_d;

    logic [1:0]      req;
    logic            winner;
    logic [XLEN-1:0] win_addr;

    assign req      = {p1_req, p0_req};
    assign win_addr = winner ? p1_addr : p0_addr;

    rr_arbiter2 u_rr (
        .clk      (clk),
        .rst      (rst),
        .req_i    (req),
        .update_i (state_q == ACCESS),
        .owner_i  (owner_q),
        .winner_o (winner)
    );

    always_comb begin
        state_d   = state_q;
        gnt_d     = 2'b00;
        done_d    = 2'b00;
        err_d     = 2'b00;
        rdata_d   = rdata_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        owner_d   = owner_q;
        cmd_err_d = cmd_err_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d        = ACCESS;
                    owner_d        = winner;
                    we_d           = winner ? p1_we : p0_we;
                    addr_d         = win_addr;
                    wdata_d        = winner ? p1_wdata : p0_wdata;
                    cmd_err_d      = (win_addr >= ADDR_LIMIT) || (win_addr[2:0] != 3'b000);
                    gnt_d[winner]  = 1'b1;
                end
            end
            default: begin
                // Stores and blocked accesses leave zero in the shared read register.
                state_d         = IDLE;
                done_d[owner_q] = 1'b1;
                err_d[owner_q]  = cmd_err_q;
                rdata_d         = mem_read ? mem_rdata : '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= 2'b00;
            done_q    <= 2'b00;
            err_q     <= 2'b00;
            rdata_q   <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            owner_q   <= PORT0;
            cmd_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            owner_q   <= owner_d;
            cmd_err_q <= cmd_err_d;
        end
    end

    // Memory strobes are decoded from live state so a store caught by reset still commits.
    assign mem_read  = (state_q == ACCESS) && !cmd_err_q && !we_q;
    assign mem_write = (state_q == ACCESS) && !cmd_err_q && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign p0_gnt   = gnt_q[0];
    assign p1_gnt   = gnt_q[1];
    assign p0_done  = done_q[0];
    assign p1_done  = done_q[1];
    assign p0_err   = err_q[0];
    assign p1_err   = err_q[1];
    assign p0_rdata = rdata_q;
    assign p1_rdata = rdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter
module tb_dmem_arbiter;
    typedef struct packed {
        logic        port;
        logic        err;
        logic [63:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_b = 2'b00;
    logic [1:0]  we_b = 2'b00;
    logic [63:0] addr_b [2];
    logic [63:0] wdata_b [2];

    logic        p0_gnt, p0_done, p0_err, p1_gnt, p1_done, p1_err;
    logic [63:0] p0_rdata, p1_rdata;
    logic        mem_read, mem_write;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  gnt, done, errs;

    logic [63:0] mem [256];
    exp_t        sb_q [$];
    exp_t        e_m;
    int          checks = 0;
    int          errors = 0;
    logic        wr_seen = 1'b0;
    logic        rd_seen = 1'b0;

    dmem_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .p0_req    (req_b[0]),
        .p0_we     (we_b[0]),
        .p0_addr   (addr_b[0]),
        .p0_wdata  (wdata_b[0]),
        .p0_gnt    (p0_gnt),
        .p0_done   (p0_done),
        .p0_err    (p0_err),
        .p0_rdata  (p0_rdata),
        .p1_req    (req_b[1]),
        .p1_we     (we_b[1]),
        .p1_addr   (addr_b[1]),
        .p1_wdata  (wdata_b[1]),
        .p1_gnt    (p1_gnt),
        .p1_done   (p1_done),
        .p1_err    (p1_err),
        .p1_rdata  (p1_rdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    assign gnt  = {p1_gnt, p0_gnt};
    assign done = {p1_done, p0_done};
    assign errs = {p1_err, p0_err};

    // Data memory model: synchronous write, read gated by read enable.
    assign mem_rdata = mem_read ? mem[mem_addr[10:3]] : 64'd0;
    always @(posedge clk) begin
        if (mem_write === 1'b1) mem[mem_addr[10:3]] <= mem_wdata;
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 64'd0;
        addr_b[0] = 64'd0; addr_b[1] = 64'd0;
        wdata_b[0] = 64'd0; wdata_b[1] = 64'd0;
    end

    always @(negedge clk) begin
        if (mem_write === 1'b1) wr_seen = 1'b1;
        if (mem_read === 1'b1) rd_seen = 1'b1;
        if (!rst) begin
            for (int p = 0; p < 2; p++) begin
                if (done[p] === 1'b1) begin
                    checks++;
                    if (sb_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_done port %0d: done with nothing outstanding", p);
                    end else begin
                        e_m = sb_q.pop_front();
                        if (e_m.port !== p[0] || errs[p] !== e_m.err ||
                            (p == 1 ? p1_rdata : p0_rdata) !== e_m.rdata) begin
                            errors++;
                            $display("FAIL completion port %0d: got err=%0b rdata=%h, want port %0d err=%0b rdata=%h",
                                     p, errs[p], (p == 1 ? p1_rdata : p0_rdata), e_m.port, e_m.err, e_m.rdata);
                        end
                    end
                end else if (errs[p] === 1'b1) begin
                    checks++;
                    errors++;
                    $display("FAIL err_without_done port %0d: err=1 done=0, want err only with done", p);
                end
            end
        end
    end

    task automatic do_access(input int p, input logic w, input logic [63:0] a,
                             input logic [63:0] d, input logic e, input logic [63:0] r);
        int n;
        sb_q.push_back('{port: p[0], err: e, rdata: r});
        req_b[p] = 1'b1; we_b[p] = w; addr_b[p] = a; wdata_b[p] = d;
        n = 0;
        do begin @(negedge clk); n++; end while (gnt[p] !== 1'b1 && n < 10);
        checks++;
        if (n != 1 || gnt[p] !== 1'b1) begin
            errors++;
            $display("FAIL gnt_latency port %0d: got %0d cycles, want 1", p, n);
        end
        req_b[p] = 1'b0;
        @(negedge clk);
        checks++;
        if (done[p] !== 1'b1) begin
            errors++;
            $display("FAIL done_latency port %0d: done=%0b in cycle 2, want 1", p, done[p]);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({gnt, done, errs, mem_read, mem_write} !== 8'd0 || p0_rdata !== 64'd0 ||
            mem_addr !== 64'd0 || mem_wdata !== 64'd0) begin
            errors++;
            $display("FAIL reset_outputs: ctl=%b rdata=%h addr=%h wdata=%h, want all zero",
                     {gnt, done, errs, mem_read, mem_write}, p0_rdata, mem_addr, mem_wdata);
        end
        checks++;
        if (wr_seen !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_write: mem_write seen=%0b, want 0", wr_seen);
        end
        rst = 1'b0;
        // Both ports request at once: the reset pointer must favour port 0.
        sb_q.push_back('{port: 1'b0, err: 1'b0, rdata: 64'd0});
        req_b = 2'b11; we_b = 2'b00; addr_b[0] = 64'h0; addr_b[1] = 64'h8;
        @(negedge clk);
        checks++;
        if (gnt !== 2'b01) begin
            errors++;
            $display("FAIL reset_rr_ptr: gnt=%b, want 01", gnt);
        end
        req_b = 2'b00;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_store_load();
        do_access(0, 1'b1, 64'h10, 64'hDEADBEEF, 1'b0, 64'd0);
        do_access(0, 1'b0, 64'h10, 64'd0, 1'b0, 64'hDEADBEEF);
    endtask

    task automatic test_contention();
        int n, grants, last, port;
        // A p1 access leaves the pointer on port 0.
        do_access(1, 1'b1, 64'h18, 64'h0123456789ABCDEF, 1'b0, 64'd0);
        for (int i = 0; i < 8; i++)
            sb_q.push_back('{port: i[0], err: 1'b0, rdata: (i[0] ? 64'h0123456789ABCDEF : 64'hDEADBEEF)});
        req_b = 2'b11; we_b = 2'b00; addr_b[0] = 64'h10; addr_b[1] = 64'h18;
        n = 0; grants = 0; last = 0;
        while (n < 40 && grants < 8) begin
            @(negedge clk);
            n++;
            if (gnt == 2'b11) begin
                checks++; errors++;
                $display("FAIL double_grant: gnt=%b, want one-hot", gnt);
            end else if (gnt != 2'b00) begin
                port = gnt[1] ? 1 : 0;
                checks++;
                if (port != grants % 2 || (grants > 0 && n - last != 2)) begin
                    errors++;
                    $display("FAIL contention_order grant %0d: port %0d after %0d cycles, want port %0d after 2",
                             grants, port, n - last, grants % 2);
                end
                last = n;
                grants++;
                if (grants == 8) req_b = 2'b00;
            end
        end
        checks++;
        if (grants != 8) begin
            errors++;
            $display("FAIL contention_count: got %0d grants, want 8", grants);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_range_errors();
        wr_seen = 1'b0; rd_seen = 1'b0;
        do_access(1, 1'b1, 64'h800, 64'hFFFF_0000_FFFF_0000, 1'b1, 64'd0);
        do_access(1, 1'b0, 64'h0C, 64'd0, 1'b1, 64'd0);
        checks++;
        if (wr_seen !== 1'b0 || rd_seen !== 1'b0) begin
            errors++;
            $display("FAIL range_strobes: write_seen=%0b read_seen=%0b, want 0 0", wr_seen, rd_seen);
        end
        checks++;
        if (mem[0] !== 64'd0) begin
            errors++;
            $display("FAIL range_no_commit: word 0 = %h, want 0", mem[0]);
        end
    endtask

    task automatic test_reset_mid_op();
        int n;
        req_b[0] = 1'b1; we_b[0] = 1'b1; addr_b[0] = 64'h08; wdata_b[0] = 64'hCAFE_F00D_1234_5678;
        n = 0;
        do begin @(negedge clk); n++; end while (p0_gnt !== 1'b1 && n < 10);
        checks++;
        if (n != 1) begin
            errors++;
            $display("FAIL midop_gnt: got %0d cycles, want 1", n);
        end
        req_b[0] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (p0_done !== 1'b0 || mem_write !== 1'b0) begin
            errors++;
            $display("FAIL midop_no_done: done=%0b mem_write=%0b, want 0 0", p0_done, mem_write);
        end
        rst = 1'b0;
        @(negedge clk);
        do_access(0, 1'b0, 64'h08, 64'd0, 1'b0, 64'hCAFE_F00D_1234_5678);
    endtask

    task automatic test_late_req();
        int n;
        sb_q.push_back('{port: 1'b0, err: 1'b0, rdata: 64'hDEADBEEF});
        sb_q.push_back('{port: 1'b1, err: 1'b0, rdata: 64'h0123456789ABCDEF});
        req_b[0] = 1'b1; we_b[0] = 1'b0; addr_b[0] = 64'h10;
        n = 0;
        do begin @(negedge clk); n++; end while (p0_gnt !== 1'b1 && n < 10);
        req_b[0] = 1'b0;
        req_b[1] = 1'b1; we_b[1] = 1'b0; addr_b[1] = 64'h18;
        @(negedge clk);
        checks++;
        if (p0_done !== 1'b1 || p1_gnt !== 1'b0) begin
            errors++;
            $display("FAIL late_req_cycle2: p0_done=%0b p1_gnt=%0b, want 1 0", p0_done, p1_gnt);
        end
        @(negedge clk);
        checks++;
        if (p1_gnt !== 1'b1) begin
            errors++;
            $display("FAIL late_req_gnt: p1_gnt=%0b, want 1", p1_gnt);
        end
        req_b[1] = 1'b0;
        @(negedge clk);
        checks++;
        if (p1_done !== 1'b1) begin
            errors++;
            $display("FAIL late_req_done: p1_done=%0b, want 1", p1_done);
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_contention();
        test_range_errors();
        test_reset_mid_op();
        test_late_req();
        repeat (3) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d completions missing, want 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
